// File: rtl/nv_nvdla_mcif_brd_pkg.sv
// Shared definitions for the MCIF read responder: pd field offsets, atom/line sizes,
// the issue FSM state type and the beat-count helper.
package nv_nvdla_mcif_brd_pkg;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 63;
  localparam int SIZE_LSB = 64;
  localparam int SIZE_MSB = 78;
  localparam int MASK_LSB = 512;

  localparam int ATOM_BYTES = 32;
  localparam int LINE_BYTES = 64;

  localparam int ATOM_SEL_BIT = ADDR_LSB + $clog2(ATOM_BYTES);
  localparam int LINE_LSB     = ADDR_LSB + $clog2(LINE_BYTES);
  localparam int LINE_W       = ADDR_MSB - LINE_LSB + 1;
  localparam int SIZE_W       = SIZE_MSB - SIZE_LSB + 1;
  localparam int REQ_PD_W     = SIZE_MSB + 1;
  localparam int DATA_W       = MASK_LSB;
  localparam int RSP_PD_W     = MASK_LSB + 2;
  localparam int BEAT_W       = 16;

  typedef enum logic {
    BRD_IDLE  = 1'b0,
    BRD_ISSUE = 1'b1
  } brd_state_e;

  // A request of size+1 atoms starting in the upper half of a line spans one extra half.
  function automatic logic [BEAT_W-1:0] brd_beats(input logic half, input logic [SIZE_W-1:0] size);
    logic [BEAT_W-1:0] atoms;
    atoms = {{(BEAT_W-1){1'b0}}, half} + {1'b0, size} + BEAT_W'(2);
    return atoms >> 1;
  endfunction

endpackage

// File: rtl/nv_nvdla_mcif_brd_fifo.sv
// Small valid/ready FIFO used both as the request queue and as the response buffer.
// wr_ready is registered so it reads 0 while reset is asserted.
module nv_nvdla_mcif_brd_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_pd,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_pd,
  output logic [CW-1:0]    count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign push     = wr_valid && ready_q;
  assign pop      = rd_valid && rd_ready;
  assign count_d  = count_q + CW'(push) - CW'(pop);
  assign wr_ready = ready_q;
  assign rd_valid = (count_q != '0);
  assign rd_pd    = mem_q[rd_ptr_q];
  assign count    = count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      count_q <= count_d;
      ready_q <= (count_d < CW'(DEPTH));
    end
  end

  // NOTE: storage is deliberately not reset; occupancy is tracked by count_q, which is.
  always_ff @(posedge nvdla_core_clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_pd;
  end

endmodule

// File: rtl/nv_nvdla_mcif_brd_responder.sv
// MCIF read responder: queues SDP read requests, issues 64 B line reads under credit
// control and returns masked beats. Optional NVDLA_MCIF_BRSP_PERF_EN adds perf_stall.
module nv_nvdla_mcif_brd_responder
  import nv_nvdla_mcif_brd_pkg::*;
#(
  parameter int CREDIT_MAX = 16,
  parameter int REQ_DEPTH  = 4
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                sdp_b2mcif_rd_req_valid,
  output logic                sdp_b2mcif_rd_req_ready,
  input  logic [REQ_PD_W-1:0] sdp_b2mcif_rd_req_pd,
  output logic                mcif2sdp_b_rd_rsp_valid,
  input  logic                mcif2sdp_b_rd_rsp_ready,
  output logic [RSP_PD_W-1:0] mcif2sdp_b_rd_rsp_pd,
  input  logic                sdp_b2mcif_rd_cdt_lat_fifo_pop,
  output logic                mem_rd_en,
  output logic [LINE_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]   mem_rd_data,
  output logic                credit_err,
`ifdef NVDLA_MCIF_BRSP_PERF_EN
  output logic [31:0]         perf_stall,
`endif
  output logic                idle
);
  localparam int CW  = $clog2(CREDIT_MAX + 1);
  localparam int QCW = $clog2(REQ_DEPTH + 1);
  localparam int OCW = $clog2(2 + 1);

  logic                rq_valid, rq_pop;
  logic [REQ_PD_W-1:0] rq_pd;
  logic [QCW-1:0]      rq_count;

  nv_nvdla_mcif_brd_fifo #(.WIDTH(REQ_PD_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .wr_valid        (sdp_b2mcif_rd_req_valid),
    .wr_ready        (sdp_b2mcif_rd_req_ready),
    .wr_pd           (sdp_b2mcif_rd_req_pd),
    .rd_valid        (rq_valid),
    .rd_ready        (rq_pop),
    .rd_pd           (rq_pd),
    .count           (rq_count)
  );

  logic [LINE_W-1:0] req_line;
  logic              req_half, req_trunc;
  logic [SIZE_W-1:0] req_size;
  logic [BEAT_W-1:0] req_beats;
  logic              unused_atom_offset;

  assign req_line  = rq_pd[ADDR_MSB:LINE_LSB];
  assign req_half  = rq_pd[ATOM_SEL_BIT];
  assign req_size  = rq_pd[SIZE_MSB:SIZE_LSB];
  assign req_beats = brd_beats(req_half, req_size);
  // An even atom-end index means the final beat only carries its lower half.
  assign req_trunc = ~(req_half ^ req_size[0]);
  assign unused_atom_offset = ^rq_pd[ATOM_SEL_BIT-1:ADDR_LSB];

  brd_state_e        state_q, state_d;
  logic [LINE_W-1:0] line_q, src_line;
  logic [BEAT_W-1:0] beats_q, src_beats;
  logic              first_q, half_q, trunc_q;
  logic              src_first, src_half, src_trunc;
  logic [CW-1:0]     credit_q;
  logic              credit_err_q;
  logic              rd_q;
  logic [1:0]        mask_q, cur_mask;
  logic              load, active, room, issue;

  logic              ob_pop, ob_wr_ready_unused;
  logic [OCW-1:0]    ob_count;

  assign ob_pop = mcif2sdp_b_rd_rsp_valid && mcif2sdp_b_rd_rsp_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load      = 1'b0;
    active    = 1'b0;
    src_line  = line_q;
    src_beats = beats_q;
    src_first = first_q;
    src_half  = half_q;
    src_trunc = trunc_q;
    cur_mask  = 2'b11;
    room      = 1'b0;
    issue     = 1'b0;
    state_d   = state_q;

    load   = (state_q == BRD_IDLE) && rq_valid;
    active = load || (state_q == BRD_ISSUE);
    if (load) begin
      src_line  = req_line;
      src_beats = req_beats;
      src_first = 1'b1;
      src_half  = req_half;
      src_trunc = req_trunc;
    end

    if (src_first && src_half) cur_mask = 2'b10;
    if ((src_beats == BEAT_W'(1)) && src_trunc) cur_mask = cur_mask & 2'b01;

    // A beat leaving the buffer this cycle frees its slot for a new read.
    room  = (3'(ob_count) + 3'(rd_q)) < (3'd2 + 3'(ob_pop));
    issue = active && (credit_q != '0) && room;

    if (active) state_d = (issue && (src_beats == BEAT_W'(1))) ? BRD_IDLE : BRD_ISSUE;
  end

  assign rq_pop      = load;
  assign mem_rd_en   = issue;
  assign mem_rd_addr = src_line;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q      <= BRD_IDLE;
      line_q       <= '0;
      beats_q      <= '0;
      first_q      <= 1'b0;
      half_q       <= 1'b0;
      trunc_q      <= 1'b0;
      rd_q         <= 1'b0;
      mask_q       <= 2'b00;
      credit_q     <= CW'(CREDIT_MAX);
      credit_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (active) begin
        line_q  <= issue ? src_line + LINE_W'(1) : src_line;
        beats_q <= issue ? src_beats - BEAT_W'(1) : src_beats;
        first_q <= src_first && !issue;
        half_q  <= src_half;
        trunc_q <= src_trunc;
      end
      rd_q <= issue;
      if (issue) mask_q <= cur_mask;
      case ({sdp_b2mcif_rd_cdt_lat_fifo_pop, issue})
        2'b10: begin
          if (credit_q == CW'(CREDIT_MAX)) credit_err_q <= 1'b1;
          else                             credit_q     <= credit_q + CW'(1);
        end
        2'b01:   credit_q <= credit_q - CW'(1);
        default: ;
      endcase
    end
  end

  // Issue gating guarantees a free slot whenever a read returns, so write readiness is implied.
  nv_nvdla_mcif_brd_fifo #(.WIDTH(RSP_PD_W), .DEPTH(2)) u_rsp_fifo (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .wr_valid        (rd_q),
    .wr_ready        (ob_wr_ready_unused),
    .wr_pd           ({mask_q, mem_rd_data}),
    .rd_valid        (mcif2sdp_b_rd_rsp_valid),
    .rd_ready        (mcif2sdp_b_rd_rsp_ready),
    .rd_pd           (mcif2sdp_b_rd_rsp_pd),
    .count           (ob_count)
  );

  assign credit_err = credit_err_q;
  assign idle = (rq_count == '0) && (state_q == BRD_IDLE) && (ob_count == '0) && !rd_q;

`ifdef NVDLA_MCIF_BRSP_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) perf_q <= '0;
    else if ((state_q == BRD_ISSUE) && (credit_q == '0) && (perf_q != '1)) perf_q <= perf_q + 32'd1;
  end
  assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_mcif_brd_responder.sv
// Directed bench for nv_nvdla_mcif_brd_responder: scoreboarded line addresses and
// response beats, latency, credit stall/overflow, backpressure and mid-burst reset.
module tb_nv_nvdla_mcif_brd_responder;
  import nv_nvdla_mcif_brd_pkg::*;

  localparam int CHK_W = RSP_PD_W;

  logic                nvdla_core_clk = 1'b0;
  logic                nvdla_core_rstn = 1'b0;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [REQ_PD_W-1:0] req_pd = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [RSP_PD_W-1:0] rsp_pd;
  logic                lat_pop = 1'b0;
  logic                mem_rd_en;
  logic [LINE_W-1:0]   mem_rd_addr;
  logic [DATA_W-1:0]   mem_rd_data = '0;
  logic                credit_err;
  logic                idle;
`ifdef NVDLA_MCIF_BRSP_PERF_EN
  logic [31:0]         perf_stall;
`endif

  nv_nvdla_mcif_brd_responder #(.CREDIT_MAX(16), .REQ_DEPTH(4)) dut (
    .nvdla_core_clk                 (nvdla_core_clk),
    .nvdla_core_rstn                (nvdla_core_rstn),
    .sdp_b2mcif_rd_req_valid        (req_valid),
    .sdp_b2mcif_rd_req_ready        (req_ready),
    .sdp_b2mcif_rd_req_pd           (req_pd),
    .mcif2sdp_b_rd_rsp_valid        (rsp_valid),
    .mcif2sdp_b_rd_rsp_ready        (rsp_ready),
    .mcif2sdp_b_rd_rsp_pd           (rsp_pd),
    .sdp_b2mcif_rd_cdt_lat_fifo_pop (lat_pop),
    .mem_rd_en                      (mem_rd_en),
    .mem_rd_addr                    (mem_rd_addr),
    .mem_rd_data                    (mem_rd_data),
    .credit_err                     (credit_err),
`ifdef NVDLA_MCIF_BRSP_PERF_EN
    .perf_stall                     (perf_stall),
`endif
    .idle                           (idle)
  );

  initial forever #5 nvdla_core_clk = ~nvdla_core_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_issue = 0;
  int n_rsp = 0;
  int cyc = 0;
  int win_cnt = 0, win_first = 0, win_last = 0;

  logic [LINE_W-1:0]   exp_line_q[$];
  logic [RSP_PD_W-1:0] exp_rsp_q[$];

  function automatic logic [DATA_W-1:0] line_data(input logic [LINE_W-1:0] line);
    return {8{6'h15, line}};
  endfunction

  task automatic check(input string tag, input logic [CHK_W-1:0] obs, input logic [CHK_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Backing memory: data for a strobed line appears in the following cycle, junk otherwise.
  initial forever begin : mem_model
    logic              en;
    logic [LINE_W-1:0] a;
    @(negedge nvdla_core_clk);
    en = mem_rd_en;
    a  = mem_rd_addr;
    @(posedge nvdla_core_clk);
    #1;
    mem_rd_data = en ? line_data(a) : {16{$urandom}};
  end

  // Monitor: scoreboard compare of issued lines and delivered beats, plus hold stability.
  initial forever begin : monitor
    logic                hold_prev;
    logic [RSP_PD_W-1:0] prev_pd;
    logic [LINE_W-1:0]   el;
    logic [RSP_PD_W-1:0] er;
    hold_prev = 1'b0;
    prev_pd   = '0;
    forever begin
      @(negedge nvdla_core_clk);
      cyc++;
      if (!nvdla_core_rstn) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("rsp_hold_valid", CHK_W'(rsp_valid), CHK_W'(1));
          check("rsp_hold_pd", rsp_pd, prev_pd);
        end
        if (mem_rd_en) begin
          n_issue++;
          if (win_cnt == 0) win_first = cyc;
          win_last = cyc;
          win_cnt++;
          n_cmp++;
          assert (exp_line_q.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_issue: observed addr %0h expected no issue", mem_rd_addr);
          end
          if (exp_line_q.size() != 0) begin
            el = exp_line_q.pop_front();
            check("mem_rd_addr", CHK_W'(mem_rd_addr), CHK_W'(el));
          end
        end
        if (rsp_valid && rsp_ready) begin
          n_rsp++;
          n_cmp++;
          assert (exp_rsp_q.size() != 0) else begin
            n_bad++;
            $error("FAIL unexpected_rsp: observed pd %0h expected no response", rsp_pd);
          end
          if (exp_rsp_q.size() != 0) begin
            er = exp_rsp_q.pop_front();
            check("rsp_pd", rsp_pd, er);
          end
        end
        hold_prev = rsp_valid && !rsp_ready;
        prev_pd   = rsp_pd;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge nvdla_core_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    nvdla_core_rstn = 1'b0;
    req_valid = 1'b0;
    req_pd    = '0;
    rsp_ready = 1'b1;
    lat_pop   = 1'b0;
    tick(2);
    check("rst_req_ready", CHK_W'(req_ready), CHK_W'(0));
    check("rst_rsp_valid", CHK_W'(rsp_valid), CHK_W'(0));
    check("rst_mem_rd_en", CHK_W'(mem_rd_en), CHK_W'(0));
    check("rst_credit_err", CHK_W'(credit_err), CHK_W'(0));
    check("rst_idle", CHK_W'(idle), CHK_W'(1));
    exp_line_q.delete();
    exp_rsp_q.delete();
    nvdla_core_rstn = 1'b1;
    tick(1);
    check("req_ready_after_reset", CHK_W'(req_ready), CHK_W'(1));
  endtask

  // Returns #1 after the accepting clock edge; expected beats are queued at that point.
  task automatic send_req(input logic [63:0] addr, input logic [SIZE_W-1:0] size);
    bit done;
    int beats;
    bit half, trunc;
    logic [1:0] m;
    logic [LINE_W-1:0] l0;
    done = 1'b0;
    req_pd    = {size, addr};
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge nvdla_core_clk);
      if (req_ready) done = 1'b1;
      @(posedge nvdla_core_clk);
      #1;
    end
    req_valid = 1'b0;
    n_cmp++;
    assert (done) else begin
      n_bad++;
      $error("FAIL req_accept: observed no handshake expected accept of addr %0h", addr);
    end
    if (done) begin
      half  = addr[5];
      beats = (int'(half) + int'(size) + 2) / 2;
      trunc = ((int'(half) + int'(size)) % 2) == 0;
      l0    = addr[63:6];
      for (int i = 0; i < beats; i++) begin
        m = 2'b11;
        if (i == 0 && half) m = 2'b10;
        if (i == beats - 1 && trunc) m = m & 2'b01;
        exp_line_q.push_back(l0 + LINE_W'(i));
        exp_rsp_q.push_back({m, line_data(l0 + LINE_W'(i))});
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (idle && exp_rsp_q.size() == 0) break;
      tick(1);
    end
    check({tag, "_idle"}, CHK_W'(idle), CHK_W'(1));
    check({tag, "_rsp_drained"}, CHK_W'(exp_rsp_q.size()), CHK_W'(0));
    check({tag, "_issue_drained"}, CHK_W'(exp_line_q.size()), CHK_W'(0));
  endtask

  task automatic pop_credits(input int n);
    lat_pop = 1'b1;
    tick(n);
    lat_pop = 1'b0;
  endtask

  initial begin : stimulus
    int ibase, rbase, rsave, k;

    do_reset();

    // Aligned 2-beat request: latency and full masks.
    send_req(64'h1000, 15'd3);
    check("t1_issue_cycle", CHK_W'(mem_rd_en), CHK_W'(1));
    check("t1_issue_addr", CHK_W'(mem_rd_addr), CHK_W'(58'h40));
    tick(1);
    check("t1_rsp_not_yet", CHK_W'(rsp_valid), CHK_W'(0));
    tick(1);
    check("t1_rsp_two_after", CHK_W'(rsp_valid), CHK_W'(1));
    wait_idle("t1");

    // Upper-half starts: partial first and last beats.
    send_req(64'h1020, 15'd1);
    wait_idle("t2a");
    send_req(64'h1020, 15'd0);
    wait_idle("t2b");

    // Back-to-back requests issue with no gap.
    win_cnt = 0;
    send_req(64'h2000, 15'd3);
    send_req(64'h3020, 15'd4);
    wait_idle("t3");
    check("t3_beats", CHK_W'(win_cnt), CHK_W'(5));
    check("t3_contiguous", CHK_W'(win_last - win_first + 1), CHK_W'(5));

    // Credit exhaustion stalls issue; one pop releases exactly one beat.
    do_reset();
    ibase = n_issue;
    rbase = n_rsp;
    send_req(64'h0, 15'd63);
    tick(40);
    check("t4_issue_16", CHK_W'(n_issue - ibase), CHK_W'(16));
    check("t4_rsp_16", CHK_W'(n_rsp - rbase), CHK_W'(16));
    pop_credits(1);
    tick(10);
    check("t4_issue_17", CHK_W'(n_issue - ibase), CHK_W'(17));
    pop_credits(15);
    wait_idle("t4");
    check("t4_issue_32", CHK_W'(n_issue - ibase), CHK_W'(32));
    check("t4_no_credit_err", CHK_W'(credit_err), CHK_W'(0));

    // Response backpressure mid-burst.
    do_reset();
    ibase = n_issue;
    rbase = n_rsp;
    send_req(64'h4000, 15'd15);
    k = 0;
    while (n_rsp - rbase < 3 && k < 50) begin
      tick(1);
      k++;
    end
    check("t5_started", CHK_W'(n_rsp - rbase >= 3), CHK_W'(1));
    rsp_ready = 1'b0;
    rsave = n_rsp;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t5_buffered_le2", CHK_W'((n_issue - ibase) - (n_rsp - rbase) <= 2), CHK_W'(1));
    end
    check("t5_no_rsp_stalled", CHK_W'(n_rsp), CHK_W'(rsave));
    rsp_ready = 1'b1;
    wait_idle("t5");
    check("t5_all_beats", CHK_W'(n_rsp - rbase), CHK_W'(8));

    // Credit overflow is sticky and saturates; pop with issue leaves credits unchanged.
    do_reset();
    pop_credits(1);
    check("t6_credit_err", CHK_W'(credit_err), CHK_W'(1));
    ibase = n_issue;
    send_req(64'h0, 15'd63);
    pop_credits(4);
    tick(40);
    check("t6_issue_20", CHK_W'(n_issue - ibase), CHK_W'(20));
    pop_credits(12);
    wait_idle("t6");
    check("t6_issue_32", CHK_W'(n_issue - ibase), CHK_W'(32));
    check("t6_err_sticky", CHK_W'(credit_err), CHK_W'(1));

    // Reset during the third beat of an 8-beat burst.
    do_reset();
    rbase = n_rsp;
    send_req(64'h8000, 15'd15);
    k = 0;
    while (n_rsp - rbase < 2 && k < 50) begin
      tick(1);
      k++;
    end
    check("t7_mid_burst", CHK_W'(n_rsp - rbase), CHK_W'(2));
    nvdla_core_rstn = 1'b0;
    tick(2);
    exp_line_q.delete();
    exp_rsp_q.delete();
    nvdla_core_rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t7_rsp_quiet", CHK_W'(rsp_valid), CHK_W'(0));
      check("t7_idle", CHK_W'(idle), CHK_W'(1));
      check("t7_no_issue", CHK_W'(mem_rd_en), CHK_W'(0));
    end
    rbase = n_rsp;
    send_req(64'h1000, 15'd3);
    wait_idle("t7");
    check("t7_new_req_beats", CHK_W'(n_rsp - rbase), CHK_W'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: observed no completion expected summary");
    $fatal(1, "watchdog expired");
  end

endmodule
